// File: rtl/serial_alu_sequencer.sv
// Bit-serial sequencer for a single-bit ALU slice: decodes an R-type funct,
// streams operand bits LSB-first, threads the carry and reassembles the result.
module serial_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             sliceA,
  output logic             sliceB,
  output logic             sliceCin,
  output logic [3:0]       sliceSignal,
  input  logic             sliceOut,
  input  logic             sliceCout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryOut,
  output logic             illegal
);

  localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, stateNext;
  logic [IDX_W-1:0] bitIdx;
  logic [3:0]       opCode;
  logic             carryQ;
  logic [WIDTH-1:0] opAQ, opBQ;
  logic [WIDTH-2:0] accQ;
  logic [4:0]       decoded;
  logic             isSubLike;
  logic             isArith;
  logic             sltSet;

  // Returns {legal, sliceCode}.
  function automatic logic [4:0] decodeFunct(input logic [5:0] f);
    case (f)
      6'd36:   return {1'b1, 4'd0};
      6'd37:   return {1'b1, 4'd1};
      6'd32:   return {1'b1, 4'd2};
      6'd34:   return {1'b1, 4'd6};
      6'd42:   return {1'b1, 4'd7};
      default: return 5'd0;
    endcase
  endfunction

  assign decoded   = decodeFunct(funct);
  assign isSubLike = (opCode == 4'd6) || (opCode == 4'd7);
  assign isArith   = isSubLike || (opCode == 4'd2);
  // Signed less-than: sum MSB corrected by overflow (carry-in vs carry-out of MSB).
  assign sltSet    = sliceOut ^ (carryQ ^ sliceCout);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = decoded[4] ? RUN : DONE;
      RUN:     if (bitIdx == LAST_IDX) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == RUN) || (state == DONE);
    done        = (state == DONE);
    sliceA      = 1'b0;
    sliceB      = 1'b0;
    sliceCin    = 1'b0;
    sliceSignal = 4'd0;
    if (state == RUN) begin
      sliceA      = opAQ[bitIdx];
      sliceB      = opBQ[bitIdx];
      sliceSignal = opCode;
      sliceCin    = (bitIdx == '0) ? isSubLike : carryQ;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitIdx   <= '0;
      opCode   <= 4'd0;
      carryQ   <= 1'b0;
      result   <= '0;
      carryOut <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opCode <= decoded[3:0];
          bitIdx <= '0;
          carryQ <= 1'b0;
          if (!decoded[4]) begin
            result   <= '0;
            carryOut <= 1'b0;
            illegal  <= 1'b1;
          end
        end
        RUN: begin
          bitIdx <= bitIdx + 1'b1;
          carryQ <= sliceCout;
          if (bitIdx == LAST_IDX) begin
            illegal  <= 1'b0;
            carryOut <= isArith ? sliceCout : 1'b0;
            result   <= (opCode == 4'd7) ? {{(WIDTH-1){1'b0}}, sltSet}
                                         : {sliceOut, accQ};
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture and partial-result assembly carry no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      opAQ <= opA;
      opBQ <= opB;
    end
    if (state == RUN && bitIdx != LAST_IDX) accQ[bitIdx] <= sliceOut;
  end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Randomized and directed bench for serial_alu_sequencer with a behavioural
// bit-slice model and a word-level arithmetic reference.
module tb_serial_alu_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [5:0]   funct;
  logic [W-1:0] opA, opB;
  logic         sliceA, sliceB, sliceCin, sliceOut, sliceCout;
  logic [3:0]   sliceSignal;
  logic         busy, done, carryOut, illegal;
  logic [W-1:0] result;
  logic         bEff;

  int nChecks = 0;
  int nFails  = 0;

  serial_alu_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .opA(opA), .opB(opB),
    .sliceA(sliceA), .sliceB(sliceB), .sliceCin(sliceCin), .sliceSignal(sliceSignal),
    .sliceOut(sliceOut), .sliceCout(sliceCout), .busy(busy), .done(done),
    .result(result), .carryOut(carryOut), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // One-bit ALU slice: full adder always active, B inverted for codes 6/7.
  always_comb begin
    bEff      = sliceB ^ ((sliceSignal == 4'd6) || (sliceSignal == 4'd7));
    sliceCout = (sliceA & bEff) | (sliceA & sliceCin) | (bEff & sliceCin);
    case (sliceSignal)
      4'd0:    sliceOut = sliceA & sliceB;
      4'd1:    sliceOut = sliceA | sliceB;
      default: sliceOut = sliceA ^ bEff ^ sliceCin;
    endcase
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void refModel(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic c, output logic ill,
                                   output logic [3:0] code);
    logic [W:0] s;
    r = '0; c = 1'b0; ill = 1'b0; code = 4'd0;
    case (f)
      6'd36: begin code = 4'd0; r = a & b; end
      6'd37: begin code = 4'd1; r = a | b; end
      6'd32: begin code = 4'd2; s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
      6'd34: begin code = 4'd6; s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1}; r = s[W-1:0]; c = s[W]; end
      6'd42: begin
        code = 4'd7;
        s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        c = s[W];
        r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      end
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic runOp(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int injectAt, input bit startInDone);
    logic [W-1:0] er;
    logic         ec, ei;
    logic [3:0]   ecode;
    int           cyc, bitErr;
    bit           seenDone;
    refModel(f, a, b, er, ec, ei, ecode);
    @(negedge clk);
    start = 1'b1; funct = f; opA = a; opB = b;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; bitErr = 0; seenDone = 0;
    while (!seenDone && cyc < W + 4) begin
      @(negedge clk);
      cyc++;
      if (done) seenDone = 1;
      else begin
        if (!busy) bitErr++;
        if (cyc <= W) begin
          if (sliceSignal !== ecode || sliceA !== a[cyc-1] || sliceB !== b[cyc-1]) bitErr++;
        end else bitErr++;
        if (cyc == 1 && sliceCin !== ((ecode == 4'd6) || (ecode == 4'd7))) bitErr++;
        if (cyc == injectAt) begin
          start = 1'b1; funct = 6'd34; opA = ~a; opB = $urandom;
        end else if (cyc == injectAt + 1) start = 1'b0;
      end
    end
    start = 1'b0;
    checkVal({tag, " latency"}, 64'(cyc), ei ? 64'd1 : 64'(W + 1));
    checkVal({tag, " busyInDone"}, 64'(busy), 64'd1);
    checkVal({tag, " result"}, 64'(result), 64'(er));
    checkVal({tag, " carryOut"}, 64'(carryOut), 64'(ec));
    checkVal({tag, " illegal"}, 64'(illegal), 64'(ei));
    checkVal({tag, " sliceDrive"}, 64'(bitErr), 64'd0);
    if (startInDone) begin
      start = 1'b1; funct = 6'd32;
      @(posedge clk);
      #1 checkVal({tag, " startInDoneIgnored"}, 64'(busy), 64'd0);
      start = 1'b0;
    end else begin
      @(negedge clk);
      checkVal({tag, " idleAfter"}, 64'({busy, done}), 64'd0);
    end
    checkVal({tag, " resultHeld"}, 64'(result), 64'(er));
  endtask

  task automatic midReset();
    int doneCount;
    @(negedge clk);
    start = 1'b1; funct = 6'd32; opA = $urandom; opB = $urandom;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checkVal("midReset outputs",
             64'({busy, done, carryOut, illegal, sliceA, sliceB, sliceCin, sliceSignal}), 64'd0);
    checkVal("midReset result", 64'(result), 64'd0);
    doneCount = 0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done || busy) doneCount++;
    end
    checkVal("midReset noDone", 64'(doneCount), 64'd0);
  endtask

  initial begin
    logic [5:0] functTab[5] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42};
    logic [5:0] rf;
    int sel;
    reset = 1'b1; start = 1'b0; funct = '0; opA = '0; opB = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkVal("reset outputs",
             64'({busy, done, carryOut, illegal, sliceA, sliceB, sliceCin, sliceSignal}), 64'd0);
    checkVal("reset result", 64'(result), 64'd0);

    runOp("add5+3", 6'd32, 32'd5, 32'd3, 0, 0);
    runOp("sub3-5", 6'd34, 32'd3, 32'd5, 0, 0);
    runOp("sub5-3", 6'd34, 32'd5, 32'd3, 0, 0);
    runOp("sltNeg", 6'd42, 32'hFFFF_FFFF, 32'd1, 0, 0);
    runOp("sltOvf", 6'd42, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0);
    runOp("sltMin", 6'd42, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0);
    runOp("and", 6'd36, 32'hF0F0_A5A5, 32'h0FF0_FF00, 0, 0);
    runOp("or", 6'd37, 32'hF0F0_A5A5, 32'h0FF0_FF00, 0, 0);
    runOp("addWrap", 6'd32, 32'hFFFF_FFFF, 32'd1, 0, 0);
    runOp("illegal0", 6'd0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1);
    runOp("addInject", 6'd32, 32'd5, 32'd3, 10, 0);
    midReset();
    runOp("addAfterReset", 6'd32, 32'h0000_FFFF, 32'h0000_0001, 0, 0);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 5);
      rf = (sel == 5) ? 6'($urandom_range(0, 63)) : functTab[sel];
      runOp($sformatf("rnd%0d", i), rf, $urandom, $urandom, 0, (i % 7) == 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
